// File: rtl/freelist_nway.sv
// freelist_nway -- physical-register free list for an R10K-style rename stage.
//
// A circular FIFO of free physical tags. Up to WAYS destination tags leave
// from the head each cycle (all-or-nothing), and up to WAYS retired Told tags
// re-enter at the tail. NUM_CKPT head snapshots let a branch mispredict restore
// the head in one cycle. Pointers carry one extra wrap bit, so
// count = tail - head covers 0..DEPTH.
//
// Optional build macro: FREELIST_DUPCHK_EN
//   Adds a NUM_PREG-bit residency bitmap. A free of a tag that is already in
//   the list is dropped and sets the sticky dup_err output.
//
// Ports
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   alloc_req      per-lane request for a destination tag (lane 0 = oldest)
//   alloc_tag      per-lane tag, lane i at [i*PREG_W +: PREG_W]; ZERO_TAG if idle
//   alloc_gnt      every requesting lane was granted this cycle
//   free_en        per-lane retire with a Told to return
//   free_tag       per-lane Told tag
//   ckpt_save      snapshot the post-allocation head into slot ckpt_id
//   recover_en     restore head from slot recover_id (allocation blocked)
//   free_count     entries currently held (0..DEPTH)
//   empty          free_count == 0
//   overflow_err   sticky: a return was dropped because the list was full
//   dup_err        (FREELIST_DUPCHK_EN only) sticky: duplicate free dropped
module freelist_nway #(
   parameter int WAYS     = 2,
   parameter int NUM_PREG = 64,
   parameter int NUM_AREG = 32,
   parameter int NUM_CKPT = 4,
   parameter int ZERO_TAG = 31,
   localparam int PREG_W  = $clog2(NUM_PREG),
   localparam int DEPTH   = NUM_PREG - NUM_AREG,
   localparam int IDX_W   = $clog2(DEPTH),
   localparam int PTR_W   = IDX_W + 1,
   localparam int CK_W    = $clog2(NUM_CKPT)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [WAYS-1:0]        alloc_req,
   output logic [WAYS*PREG_W-1:0] alloc_tag,
   output logic                   alloc_gnt,
   input  logic [WAYS-1:0]        free_en,
   input  logic [WAYS*PREG_W-1:0] free_tag,
   input  logic                   ckpt_save,
   input  logic [CK_W-1:0]        ckpt_id,
   input  logic                   recover_en,
   input  logic [CK_W-1:0]        recover_id,
   output logic [PREG_W-1:0]      free_count,
   output logic                   empty,
   output logic                   overflow_err
`ifdef FREELIST_DUPCHK_EN
   ,
   output logic                   dup_err
`endif
);

   typedef logic [PTR_W-1:0] ptr_t;

   ptr_t                         head_q, tail_q;
   ptr_t                         count, n_req, n_gnt, head_alloc, room, m_acc;
   ptr_t                         ckpt_q [NUM_CKPT];
   logic [PREG_W-1:0]            entry_q [DEPTH];
   logic                         gnt, drop, ovf_q;
   logic [WAYS-1:0][PREG_W-1:0]  tag_lane, ftag_lane;
   logic [WAYS-1:0]              wr_en;
   logic [WAYS-1:0][IDX_W-1:0]   wr_idx;
   logic                         take;

`ifdef FREELIST_DUPCHK_EN
   logic [NUM_PREG-1:0]          in_list_q;
   logic                         dup_hit, dup_q;
   ptr_t                         rec_span;
`endif

   assign count     = tail_q - head_q;
   assign ftag_lane = free_tag;

   // Requesting lanes are compacted in lane order: the k-th requester reads
   // entry[head+k]. Tags are presented even when the grant fails.
   always_comb begin
      n_req    = '0;
      tag_lane = '0;
      for (int i = 0; i < WAYS; i++) begin
         tag_lane[i] = PREG_W'(ZERO_TAG);
         if (alloc_req[i]) begin
            tag_lane[i] = entry_q[IDX_W'(head_q + n_req)];
            n_req       = n_req + PTR_W'(1);
         end
      end
   end

   assign gnt        = ~reset & ~recover_en & (n_req <= count);
   assign n_gnt      = gnt ? n_req : '0;
   assign head_alloc = head_q + n_gnt;
   // Space left after this cycle's grant; returns beyond it are dropped.
   assign room       = PTR_W'(DEPTH) - (count - n_gnt);

   // Returning lanes (excluding the zero register) are compacted at the tail.
   always_comb begin
      m_acc  = '0;
      drop   = 1'b0;
      wr_en  = '0;
      wr_idx = '0;
      take   = 1'b0;
`ifdef FREELIST_DUPCHK_EN
      dup_hit = 1'b0;
`endif
      for (int i = 0; i < WAYS; i++) begin
         take = free_en[i] && (ftag_lane[i] != PREG_W'(ZERO_TAG));
`ifdef FREELIST_DUPCHK_EN
         // Already resident, or already accepted from an older lane this cycle.
         if (take && in_list_q[ftag_lane[i]]) begin
            take    = 1'b0;
            dup_hit = 1'b1;
         end
         for (int j = 0; j < i; j++) begin
            if (take && wr_en[j] && (ftag_lane[j] == ftag_lane[i])) begin
               take    = 1'b0;
               dup_hit = 1'b1;
            end
         end
`endif
         if (take) begin
            if (m_acc < room) begin
               wr_en[i]  = 1'b1;
               wr_idx[i] = IDX_W'(tail_q + m_acc);
               m_acc     = m_acc + PTR_W'(1);
            end else begin
               drop = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= PTR_W'(DEPTH);
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= PREG_W'(NUM_AREG + i);
         for (int c = 0; c < NUM_CKPT; c++) ckpt_q[c] <= '0;
         ovf_q  <= 1'b0;
      end else begin
         head_q <= recover_en ? ckpt_q[recover_id] : head_alloc;
         tail_q <= tail_q + m_acc;
         for (int i = 0; i < WAYS; i++) begin
            if (wr_en[i]) entry_q[wr_idx[i]] <= ftag_lane[i];
         end
         // A save in a recovery cycle would capture a squashed head; ignore it.
         if (ckpt_save && !recover_en) ckpt_q[ckpt_id] <= head_alloc;
         if (drop) ovf_q <= 1'b1;
      end
   end

`ifdef FREELIST_DUPCHK_EN
   // Tags handed out since the restored checkpoint are back in the list.
   assign rec_span = head_q - ckpt_q[recover_id];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int t = 0; t < NUM_PREG; t++) in_list_q[t] <= (t >= NUM_AREG);
         dup_q <= 1'b0;
      end else begin
         if (gnt) begin
            for (int i = 0; i < WAYS; i++) begin
               if (alloc_req[i]) in_list_q[tag_lane[i]] <= 1'b0;
            end
         end
         if (recover_en) begin
            for (int d = 0; d < DEPTH; d++) begin
               if (PTR_W'(d) < rec_span)
                  in_list_q[entry_q[IDX_W'(ckpt_q[recover_id] + PTR_W'(d))]] <= 1'b1;
            end
         end
         for (int i = 0; i < WAYS; i++) begin
            if (wr_en[i]) in_list_q[ftag_lane[i]] <= 1'b1;
         end
         if (dup_hit) dup_q <= 1'b1;
      end
   end

   assign dup_err = dup_q;
`endif

   assign alloc_tag    = tag_lane;
   assign alloc_gnt    = gnt;
   assign free_count   = PREG_W'(count);
   assign empty        = (count == '0);
   assign overflow_err = ovf_q;

endmodule
